// File: rtl/rx_param.sv
// rx_param: parametrised UART receiver with 3-sample majority voting,
// false-start rejection and parity / framing / break reporting.
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_rate         oversampling tick (one-clock pulse)
//   i_bit_rx       serial line, idles high, asynchronous
//   o_rx_done      one-clock pulse when a frame completes
//   o_data_out     received word, LSB = first data bit
//   o_parity_error parity mismatch on the last frame
//   o_frame_error  a stop bit sampled 0 on the last frame
//   o_break        break detected on the last frame
module rx_param #(
  parameter int unsigned WIDTH_WORD    = 8,
  parameter int unsigned CANT_BIT_STOP = 2,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned PARITY_EN     = 1,
  parameter int unsigned PARITY_ODD    = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rate,
  input  logic                  i_bit_rx,
  output logic                  o_rx_done,
  output logic [WIDTH_WORD-1:0] o_data_out,
  output logic                  o_parity_error,
  output logic                  o_frame_error,
  output logic                  o_break
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(WIDTH_WORD);
  localparam int unsigned SW = (CANT_BIT_STOP > 1) ? $clog2(CANT_BIT_STOP) : 1;
  localparam int unsigned M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH_WORD - 1);
  localparam logic [SW-1:0] S_LAST = SW'(CANT_BIT_STOP - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         cnt, cnt_nxt;
  logic [BW-1:0]         bit_idx, bit_nxt;
  logic [SW-1:0]         stop_cnt, stop_nxt;
  logic                  rx_meta, rx;
  logic                  s0, s1;
  logic [WIDTH_WORD-1:0] data_sh;
  logic                  par_bit;
  logic                  frame_err;

  logic maj_c, decide_c, wrap_c, done_c, brk_c, start_c, par_err_c;

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= i_bit_rx;
      rx      <= rx_meta;
    end
  end

  // State and counter registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      stop_cnt <= stop_nxt;
    end
  end

  // Majority of the samples at M-1, M and the current rx at M+1
  assign maj_c     = (s0 & s1) | (s0 & rx) | (s1 & rx);
  assign par_err_c = (PARITY_EN != 0) ? ((^data_sh) ^ par_bit ^ 1'(PARITY_ODD)) : 1'b0;

  // Next-state and counter logic; nothing moves without a tick
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_cnt;
    done_c    = 1'b0;
    brk_c     = 1'b0;
    start_c   = 1'b0;
    decide_c  = i_rate && (cnt == T_DEC);
    wrap_c    = i_rate && (cnt == T_LAST);
    if (i_rate) begin
      cnt_nxt = wrap_c ? '0 : cnt + TW'(1);
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (!rx) begin
            state_nxt = START;
            start_c   = 1'b1;
          end
        end
        START: begin
          if (decide_c && maj_c) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (wrap_c) begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end
        end
        DATA: begin
          if (wrap_c) begin
            if (bit_idx == B_LAST) begin
              state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
              stop_nxt  = '0;
            end else begin
              bit_nxt = bit_idx + BW'(1);
            end
          end
        end
        PARITY: begin
          if (wrap_c) begin
            state_nxt = STOP;
            stop_nxt  = '0;
          end
        end
        STOP: begin
          if (decide_c) begin
            // Break completes the frame at the first stop decision
            brk_c = (stop_cnt == '0) && (data_sh == '0) && !maj_c &&
                    ((PARITY_EN == 0) || !par_bit);
            if (brk_c || (stop_cnt == S_LAST)) begin
              done_c    = 1'b1;
              state_nxt = brk_c ? BRK_WAIT : IDLE;
              cnt_nxt   = '0;
            end
          end else if (wrap_c) begin
            stop_nxt = stop_cnt + SW'(1);
          end
        end
        BRK_WAIT: begin
          cnt_nxt = '0;
          if (rx) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Sampling, shift register, error tracking and registered outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      s0             <= 1'b0;
      s1             <= 1'b0;
      data_sh        <= '0;
      par_bit        <= 1'b0;
      frame_err      <= 1'b0;
      o_rx_done      <= 1'b0;
      o_data_out     <= '0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
      o_break        <= 1'b0;
    end else begin
      o_rx_done <= done_c;
      if (i_rate && (cnt == T_S0)) s0 <= rx;
      if (i_rate && (cnt == T_S1)) s1 <= rx;
      if (start_c) frame_err <= 1'b0;
      if (decide_c && (state == DATA)) data_sh[bit_idx] <= maj_c;
      if (decide_c && (state == PARITY)) par_bit <= maj_c;
      if (decide_c && (state == STOP) && !maj_c) frame_err <= 1'b1;
      if (done_c) begin
        o_data_out     <= data_sh;
        o_parity_error <= par_err_c;
        o_frame_error  <= frame_err | ~maj_c;
        o_break        <= brk_c;
      end
    end
  end

endmodule

// File: tb/tb_rx_param.sv
// tb_rx_param: directed, table-driven bench for rx_param. Instance a uses
// default parameters; instance b uses 7 data bits, no parity, 1 stop bit,
// oversampling 8.
module tb_rx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rate = 1'b0;
  logic       line_a = 1'b1;
  logic       line_b = 1'b1;
  logic       done_a, pe_a, fe_a, brk_a;
  logic [7:0] data_a;
  logic       done_b, pe_b, fe_b, brk_b;
  logic [6:0] data_b;

  int n_chk = 0;
  int n_fail = 0;
  int nd_a = 0;
  int nd_b = 0;
  int div = 0;

  rx_param u_a (
    .i_clock(clk), .i_reset(rst_n), .i_rate(rate), .i_bit_rx(line_a),
    .o_rx_done(done_a), .o_data_out(data_a), .o_parity_error(pe_a),
    .o_frame_error(fe_a), .o_break(brk_a)
  );

  rx_param #(
    .WIDTH_WORD(7), .CANT_BIT_STOP(1), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_b (
    .i_clock(clk), .i_reset(rst_n), .i_rate(rate), .i_bit_rx(line_b),
    .o_rx_done(done_b), .o_data_out(data_b), .o_parity_error(pe_b),
    .o_frame_error(fe_b), .o_break(brk_b)
  );

  always #5 clk = ~clk;

  // Tick every 4 clocks, changed on the falling edge
  always @(negedge clk) begin
    div  <= (div + 1) % 4;
    rate <= (div == 3);
  end

  // Count clocks with o_rx_done high (one per frame for a one-clock pulse)
  always @(negedge clk) begin
    if (done_a === 1'b1) nd_a <= nd_a + 1;
    if (done_b === 1'b1) nd_b <= nd_b + 1;
  end

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       s1;
    logic       s2;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
    logic       ebrk;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (rate !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    @(negedge clk);
    if (sel) line_b = v;
    else line_a = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] d, input int w, input bit pen,
                            input logic par, input int nstop, input logic s1,
                            input logic s2, input int os);
    wait_ticks(1);
    drive(sel, 1'b0, os);
    for (int i = 0; i < w; i++) drive(sel, d[i], os);
    if (pen) drive(sel, par, os);
    drive(sel, s1, os);
    if (nstop > 1) drive(sel, s2, os);
    drive(sel, 1'b1, 2 * os);
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input int base, input logic [7:0] ed,
                       input logic epe, input logic efe, input logic ebrk);
    chk({tag, " done"}, 32'(nd_a - base), 32'd1);
    chk({tag, " data"}, 32'(data_a), 32'(ed));
    chk({tag, " perr"}, 32'(pe_a), 32'(epe));
    chk({tag, " ferr"}, 32'(fe_a), 32'(efe));
    chk({tag, " brk"}, 32'(brk_a), 32'(ebrk));
  endtask

  task automatic chk_b(input string tag, input int base, input logic [6:0] ed,
                       input logic efe, input logic ebrk);
    chk({tag, " done"}, 32'(nd_b - base), 32'd1);
    chk({tag, " data"}, 32'(data_b), 32'(ed));
    chk({tag, " perr"}, 32'(pe_b), 32'd0);
    chk({tag, " ferr"}, 32'(fe_b), 32'(efe));
    chk({tag, " brk"}, 32'(brk_b), 32'(ebrk));
  endtask

  initial begin
    int base;
    //           d      par   s1    s2    ed     pe    fe    brk
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst data", 32'(data_a), 32'd0);
    chk("rst perr", 32'(pe_a), 32'd0);
    chk("rst ferr", 32'(fe_a), 32'd0);
    chk("rst brk", 32'(brk_a), 32'd0);
    chk("rst data b", 32'(data_b), 32'd0);
    rst_n = 1'b1;
    wait_ticks(20);

    // Table of complete frames on instance a
    for (int i = 0; i < 8; i++) begin
      base = nd_a;
      send_frame(1'b0, {1'b0, tbl[i].d}, 8, 1'b1, tbl[i].par, 2, tbl[i].s1, tbl[i].s2, 16);
      chk_a($sformatf("vec%0d", i), base, tbl[i].ed, tbl[i].epe, tbl[i].efe, tbl[i].ebrk);
    end

    // False start: line low for 4 ticks only
    base = nd_a;
    wait_ticks(1);
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 32);
    chk("false start done", 32'(nd_a - base), 32'd0);
    base = nd_a;
    send_frame(1'b0, 9'h055, 8, 1'b1, 1'b0, 2, 1'b1, 1'b1, 16);
    chk_a("after false start", base, 8'h55, 1'b0, 1'b0, 1'b0);

    // Single-tick glitch at counter = M inside data bit 0 of 0x00
    base = nd_a;
    wait_ticks(1);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b0, 9);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 6);
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 32);
    chk_a("glitch", base, 8'h00, 1'b0, 1'b0, 1'b0);

    // Line low for 30 bit times: exactly one break frame
    base = nd_a;
    wait_ticks(1);
    drive(1'b0, 1'b0, 30 * 16);
    chk_a("break", base, 8'h00, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 32);
    base = nd_a;
    send_frame(1'b0, 9'h081, 8, 1'b1, 1'b0, 2, 1'b1, 1'b1, 16);
    chk_a("after break", base, 8'h81, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of data bit 3
    base = nd_a;
    wait_ticks(1);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 8);
    @(negedge clk);
    rst_n  = 1'b0;
    line_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("in reset done cnt", 32'(nd_a - base), 32'd0);
    chk("in reset data", 32'(data_a), 32'd0);
    chk("in reset ferr", 32'(fe_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(40);
    chk("after reset done cnt", 32'(nd_a - base), 32'd0);
    send_frame(1'b0, 9'h07E, 8, 1'b1, 1'b0, 2, 1'b1, 1'b1, 16);
    chk_a("after reset", base, 8'h7E, 1'b0, 1'b0, 1'b0);

    // Instance b: 7 bits, no parity, 1 stop bit, oversample 8
    base = nd_b;
    send_frame(1'b1, 9'h05A, 7, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8);
    chk_b("b 5A", base, 7'h5A, 1'b0, 1'b0);
    base = nd_b;
    send_frame(1'b1, 9'h07F, 7, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8);
    chk_b("b 7F ferr", base, 7'h7F, 1'b1, 1'b0);
    base = nd_b;
    send_frame(1'b1, 9'h000, 7, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8);
    chk_b("b break", base, 7'h00, 1'b1, 1'b1);
    base = nd_b;
    send_frame(1'b1, 9'h033, 7, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8);
    chk_b("b 33", base, 7'h33, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
